// File: rtl/dsp_arith_pkg.sv
// dsp_arith_pkg: shared arithmetic helpers for the DSP datapath (adder tree sizing, signed saturation).
package dsp_arith_pkg;
   localparam int SUM_TREE_MAX_IN = 16;
   localparam int MAX_W = 128;
   function automatic int clog2(input int n);
      int r = 0;
      for (int v = n - 1; v > 0; v >>= 1) r++;
      return r;
   endfunction
   // Element count at tree level s: ceil(n / 2^s).
   function automatic int level_cnt(input int n, input int s);
      return (n + (1 << s) - 1) >> s;
   endfunction
   function automatic logic signed [MAX_W-1:0] sat_signed(input logic signed [MAX_W-1:0] value, input int width);
      logic signed [MAX_W-1:0] hi, lo;
      hi = (MAX_W'(1) <<< (width - 1)) - 1;
      lo = -hi - 1;
      return (value > hi) ? hi : (value < lo) ? lo : value;
   endfunction
endpackage

// File: rtl/pipelined_sum_tree_if.sv
// pipelined_sum_tree_if: valid/ready operand and result bundle for the pipelined sum tree.
interface pipelined_sum_tree_if #(parameter int DATA_W = 64, parameter int NUM_IN = 4);
   logic [NUM_IN*DATA_W-1:0] in_data;
   logic in_valid;
   logic in_ready;
   logic [DATA_W-1:0] out_data;
   logic out_ovf;
   logic out_valid;
   logic out_ready;
   modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_ovf, out_valid);
   modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_ovf, out_valid);
endinterface

// File: rtl/sum_tree_level.sv
// sum_tree_level: one registered pairwise-add level; an odd leftover element passes through registered.
module sum_tree_level
   import dsp_arith_pkg::*;
#(
   parameter int N_IN = 2,
   parameter int W = 66
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic in_valid,
   input  logic [N_IN*W-1:0] in_data,
   output logic out_valid,
   output logic [level_cnt(N_IN, 1)*W-1:0] out_data
);
   localparam int N_OUT = level_cnt(N_IN, 1);
   logic [N_OUT*W-1:0] pair, sum_d, sum_q;
   logic valid_d, valid_q;
   for (genvar j = 0; j < N_OUT; j++) begin : g_pair
      if (2*j + 1 < N_IN) begin : g_add
         assign pair[j*W +: W] = in_data[2*j*W +: W] + in_data[(2*j+1)*W +: W];
      end else begin : g_pass
         assign pair[j*W +: W] = in_data[2*j*W +: W];
      end
   end
   always_comb begin
      sum_d = en ? pair : sum_q;
      valid_d = en ? in_valid : valid_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         valid_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         valid_q <= valid_d;
      end
   end
   assign out_data = sum_q;
   assign out_valid = valid_q;
endmodule

// File: rtl/pipelined_sum_tree.sv
// pipelined_sum_tree: NUM_IN-operand signed adder tree, LAT registered levels, global-stall valid/ready.
// Define SUM_TREE_SAT_EN to saturate out_data on overflow instead of wrapping.
module pipelined_sum_tree
   import dsp_arith_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int NUM_IN = 4
) (
   input logic clk,
   input logic rst_n,
   pipelined_sum_tree_if.slave bus
);
   localparam int LAT = (clog2(NUM_IN) > 1) ? clog2(NUM_IN) : 1;
   localparam int FW = DATA_W + LAT;
   logic adv;
   logic [NUM_IN*FW-1:0] ext;
   logic [NUM_IN*FW-1:0] lvl [LAT+1];
   logic vld [LAT+1];
   logic signed [FW-1:0] sum;
   logic signed [MAX_W-1:0] sum_x, sat;
   assign adv = bus.out_ready | ~vld[LAT];
   assign bus.in_ready = adv;
   // Widening by LAT bits up front keeps every partial sum exact.
   for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
      assign ext[k*FW +: FW] = {{LAT{bus.in_data[k*DATA_W + DATA_W - 1]}}, bus.in_data[k*DATA_W +: DATA_W]};
   end
   assign lvl[0] = ext;
   assign vld[0] = bus.in_valid;
   for (genvar s = 0; s < LAT; s++) begin : g_lvl
      localparam int NI = level_cnt(NUM_IN, s);
      localparam int NO = level_cnt(NUM_IN, s + 1);
      logic [NO*FW-1:0] lvl_sum;
      sum_tree_level #(.N_IN(NI), .W(FW)) u_lvl (
         .clk(clk),
         .rst_n(rst_n),
         .en(adv),
         .in_valid(vld[s]),
         .in_data(lvl[s][NI*FW-1:0]),
         .out_valid(vld[s+1]),
         .out_data(lvl_sum)
      );
      assign lvl[s+1] = (NUM_IN*FW)'(lvl_sum);
   end
   assign sum = lvl[LAT][FW-1:0];
   assign sum_x = MAX_W'(sum);
   assign sat = sat_signed(sum_x, DATA_W);
   assign bus.out_valid = vld[LAT];
   assign bus.out_ovf = sat != sum_x;
`ifdef SUM_TREE_SAT_EN
   assign bus.out_data = sat[DATA_W-1:0];
`else
   assign bus.out_data = sum[DATA_W-1:0];
`endif
endmodule

// File: tb/tb_pipelined_sum_tree.sv
// tb_pipelined_sum_tree: directed bench with scoreboard for 4-operand tree plus 3- and 1-operand instances.
module tb_pipelined_sum_tree;
   localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
`ifdef SUM_TREE_SAT_EN
   localparam logic [63:0] POS_EXP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] NEG_EXP = 64'h8000_0000_0000_0000;
`else
   localparam logic [63:0] POS_EXP = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [63:0] NEG_EXP = 64'h0000_0000_0000_0000;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int passed = 0;
   logic [64:0] sb [$];
   always #5 clk = ~clk;
   pipelined_sum_tree_if #(.DATA_W(64), .NUM_IN(4)) b4 ();
   pipelined_sum_tree_if #(.DATA_W(64), .NUM_IN(3)) b3 ();
   pipelined_sum_tree_if #(.DATA_W(64), .NUM_IN(1)) b1 ();
   pipelined_sum_tree #(.DATA_W(64), .NUM_IN(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   pipelined_sum_tree #(.DATA_W(64), .NUM_IN(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   pipelined_sum_tree #(.DATA_W(64), .NUM_IN(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   function automatic logic [255:0] pack4(input longint a, input longint b, input longint c, input longint d);
      return {64'(d), 64'(c), 64'(b), 64'(a)};
   endfunction
   // Reference: exact 128-bit sum, then range test and wrap/clamp.
   function automatic logic [64:0] model(input logic [255:0] d);
      logic signed [127:0] s = 0;
      logic ovf;
      logic [63:0] r;
      for (int k = 0; k < 4; k++) s += 128'($signed(d[k*64 +: 64]));
      ovf = (s > 128'sh7FFF_FFFF_FFFF_FFFF) || (s < -128'sh8000_0000_0000_0000);
`ifdef SUM_TREE_SAT_EN
      r = !ovf ? s[63:0] : (s < 0) ? MINV : MAXV;
`else
      r = s[63:0];
`endif
      return {ovf, r};
   endfunction
   always @(posedge clk)
      if (rst_n && b4.in_valid && b4.in_ready) sb.push_back(model(b4.in_data));
   always @(negedge clk) begin : mon
      logic [64:0] e;
      if (rst_n && b4.out_valid && b4.out_ready) begin
         if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
         else begin
            e = sb.pop_front();
            check("sb_data", b4.out_data, e[63:0]);
            check("sb_ovf", 64'(b4.out_ovf), 64'(e[64]));
         end
      end
   end
   initial begin
      #200000;
      $fatal(1, "FAIL watchdog: simulation time limit reached");
   end
   initial begin
      b4.in_data = '0; b4.in_valid = 0; b4.out_ready = 1;
      b3.in_data = '0; b3.in_valid = 0; b3.out_ready = 1;
      b1.in_data = '0; b1.in_valid = 0; b1.out_ready = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 64'(b4.out_valid), 0);
      check("rst_data", b4.out_data, 0);
      check("rst_ovf", 64'(b4.out_ovf), 0);
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      check("rst_in_ready", 64'(b4.in_ready), 1);
      check("n3_in_ready", 64'(b3.in_ready), 1);
      check("n1_in_ready", 64'(b1.in_ready), 1);
      check("rst_valid_after", 64'(b4.out_valid), 0);
      @(posedge clk); #1;
      b4.in_data = pack4(5, -3, 100, -2); b4.in_valid = 1;
      @(posedge clk); #1 b4.in_valid = 0;
      @(negedge clk); check("lat_early", 64'(b4.out_valid), 0);
      @(negedge clk); check("lat_valid", 64'(b4.out_valid), 1);
      check("basic_data", b4.out_data, 100);
      check("basic_ovf", 64'(b4.out_ovf), 0);
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         b4.in_data = pack4(i, i, i, i); b4.in_valid = 1;
         @(negedge clk);
         if (i >= 2) check("stream_gap", 64'(b4.out_valid), 1);
         @(posedge clk); #1;
      end
      b4.in_valid = 0;
      repeat (2) begin
         @(negedge clk); check("stream_tail", 64'(b4.out_valid), 1);
      end
      @(negedge clk); check("stream_end", 64'(b4.out_valid), 0);
      @(posedge clk); #1;
      b4.in_data = pack4(1, 2, 3, 4); b4.in_valid = 1;
      @(posedge clk); #1 b4.out_ready = 0; b4.in_data = pack4(10, 10, 10, 10);
      @(posedge clk); #1 b4.in_data = pack4(7, 7, 7, 7);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(b4.in_ready), 0);
         check("bp_valid", 64'(b4.out_valid), 1);
         check("bp_data", b4.out_data, 10);
         @(posedge clk); #1;
      end
      b4.out_ready = 1;
      @(negedge clk); check("bp_release", 64'(b4.in_ready), 1);
      @(posedge clk); #1 b4.in_valid = 0;
      repeat (4) @(posedge clk);
      #1 b4.in_data = {4{MAXV}}; b4.in_valid = 1;
      @(posedge clk); #1 b4.in_data = {4{MINV}};
      @(posedge clk); #1 b4.in_valid = 0;
      @(negedge clk);
      check("ovf_pos_flag", 64'(b4.out_ovf), 1);
      check("ovf_pos_data", b4.out_data, POS_EXP);
      @(negedge clk);
      check("ovf_neg_flag", 64'(b4.out_ovf), 1);
      check("ovf_neg_data", b4.out_data, NEG_EXP);
      @(posedge clk); #1;
      b4.in_valid = 1;
      b4.in_data = {64'd0, 64'd0, 64'd0, MAXV};
      @(posedge clk); #1 b4.in_data = {64'd0, 64'd0, 64'd1, MAXV};
      @(posedge clk); #1 b4.in_data = {64'd0, 64'd0, 64'd0, MINV};
      @(posedge clk); #1 b4.in_data = {64'd0, 64'd0, {64{1'b1}}, MINV};
      @(posedge clk); #1 b4.in_data = {MINV, MINV, MAXV, MAXV};
      @(posedge clk); #1 b4.in_valid = 0;
      repeat (4) @(posedge clk);
      #1;
      b3.in_data = {64'(-4), 64'(2), 64'(1)}; b3.in_valid = 1;
      b1.in_data = 64'(-7); b1.in_valid = 1;
      @(posedge clk); #1 b3.in_valid = 0; b1.in_valid = 0;
      @(negedge clk);
      check("n3_early", 64'(b3.out_valid), 0);
      check("n1_valid", 64'(b1.out_valid), 1);
      check("n1_data", b1.out_data, 64'(-7));
      check("n1_ovf", 64'(b1.out_ovf), 0);
      @(negedge clk);
      check("n3_valid", 64'(b3.out_valid), 1);
      check("n3_data", b3.out_data, 64'(-1));
      check("n3_ovf", 64'(b3.out_ovf), 0);
      check("n1_bubble", 64'(b1.out_valid), 0);
      @(posedge clk); #1;
      b4.in_data = pack4(1, 1, 1, 1); b4.in_valid = 1;
      @(posedge clk); #1 b4.in_data = pack4(2, 2, 2, 2);
      @(posedge clk); #1 check("arst_pre", 64'(b4.out_valid), 1);
      #2 rst_n = 0; b4.in_valid = 0;
      #1;
      check("arst_valid", 64'(b4.out_valid), 0);
      check("arst_data", b4.out_data, 0);
      check("arst_ovf", 64'(b4.out_ovf), 0);
      sb.delete();
      @(posedge clk); #1 rst_n = 1;
      repeat (3) begin
         @(negedge clk); check("arst_quiet", 64'(b4.out_valid), 0);
      end
      @(posedge clk); #1 b4.in_data = pack4(3, 3, 3, 3); b4.in_valid = 1;
      @(posedge clk); #1 b4.in_valid = 0;
      @(negedge clk); check("arst_new_early", 64'(b4.out_valid), 0);
      @(negedge clk); check("arst_new_valid", 64'(b4.out_valid), 1);
      check("arst_new_data", b4.out_data, 12);
      repeat (3) @(posedge clk);
      #1 check("sb_empty", 64'(sb.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
